// File: rtl/snn_inference_sequencer.sv
// snn_inference_sequencer
// Runs one inference of the spiking network. It latches an input pattern,
// clears the neurons, and drives the pattern for TIMESTEPS cycles. It then
// drains the in-flight spikes and counts the output spikes per class. Last,
// it does a sequential argmax over the counters and reports the winning class.
// Optional build macro: SNN_SEQ_EARLY_EXIT_EN. When this macro is defined,
// RUN ends as soon as any class counter reaches EARLY_COUNT.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start_i, neurons disabled
// S_CLEAR  | one-cycle neuron clear, counters and timestep timer reset
// S_RUN    | pattern driven, neurons enabled, spikes counted
// S_DRAIN  | pattern removed, neurons still enabled to flush spikes
// S_ARGMAX | one counter examined per cycle, index 0 upward
// S_DONE   | one-cycle result-valid pulse
module snn_inference_sequencer #(
   parameter int NUM_INPUTS  = 8,
   parameter int NUM_OUTPUTS = 10,
   parameter int CNT_W       = 8,
   parameter int TIMESTEPS   = 64,
   parameter int PIPE_LAT    = 2,
   parameter int EARLY_COUNT = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [NUM_INPUTS-1:0]  pattern_i,
   input  logic [NUM_OUTPUTS-1:0] output_spike_i,
   output logic [NUM_INPUTS-1:0]  input_drive_o,
   output logic                   neuron_en_o,
   output logic                   neuron_clr_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [3:0]             class_o,
   output logic [CNT_W-1:0]       class_count_o,
   output logic                   tie_o
);

   localparam int IDX_W   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
   localparam int TMR_MAX = (TIMESTEPS > PIPE_LAT) ? TIMESTEPS : PIPE_LAT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] RUN_LOAD   = TMR_W'(TIMESTEPS - 1);
   localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUTPUTS - 1);

`ifdef SNN_SEQ_EARLY_EXIT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_ARGMAX,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [NUM_INPUTS-1:0] pattern_q;
   logic [TMR_W-1:0]      tmr;
   logic [IDX_W-1:0]      idx;
   logic [CNT_W-1:0]      cnt     [NUM_OUTPUTS];
   logic [CNT_W-1:0]      cnt_upd [NUM_OUTPUTS];
   logic                  early_hit;
   logic                  tmr_zero;
   logic                  idx_last;

   logic [CNT_W-1:0]      cur;
   logic [CNT_W-1:0]      am_max, am_max_n;
   logic [IDX_W-1:0]      am_best, am_best_n;
   logic                  am_tie, am_tie_n;

   assign tmr_zero = (tmr == '0);
   assign idx_last = (idx == IDX_LAST);

   // Saturating per-class count update, plus the early-exit threshold check
   always_comb begin
      early_hit = 1'b0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         cnt_upd[i] = cnt[i];
         if (output_spike_i[i] && (cnt[i] != {CNT_W{1'b1}}))
            cnt_upd[i] = cnt[i] + CNT_W'(1);
         if (32'(cnt_upd[i]) >= 32'(EARLY_COUNT))
            early_hit = 1'b1;
      end
      early_hit = early_hit & EARLY_EN;
   end

   // One argmax step; ties keep the earlier (lower) index
   always_comb begin
      cur       = cnt[idx];
      am_max_n  = am_max;
      am_best_n = am_best;
      am_tie_n  = am_tie;
      if (idx == '0) begin
         am_max_n  = cur;
         am_best_n = '0;
         am_tie_n  = 1'b0;
      end else if (cur > am_max) begin
         am_max_n  = cur;
         am_best_n = idx;
         am_tie_n  = 1'b0;
      end else if (cur == am_max) begin
         am_tie_n  = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Next-state and Moore outputs; abort overrides every transition out of IDLE-excluded states
   always_comb begin
      state_next    = state;
      input_drive_o = '0;
      neuron_en_o   = 1'b0;
      neuron_clr_o  = 1'b0;
      busy_o        = 1'b1;
      done_o        = 1'b0;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i)
               state_next = S_CLEAR;
         end
         S_CLEAR: begin
            neuron_clr_o = 1'b1;
            state_next   = S_RUN;
         end
         S_RUN: begin
            neuron_en_o   = 1'b1;
            input_drive_o = pattern_q;
            if (tmr_zero || early_hit)
               state_next = (PIPE_LAT > 0) ? S_DRAIN : S_ARGMAX;
         end
         S_DRAIN: begin
            neuron_en_o = 1'b1;
            if (tmr_zero)
               state_next = S_ARGMAX;
         end
         S_ARGMAX: begin
            if (idx_last)
               state_next = S_DONE;
         end
         S_DONE: begin
            done_o     = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (abort_i && (state != S_IDLE))
         state_next = S_IDLE;
   end

   // Datapath: pattern latch, timers, spike counters, argmax and result registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pattern_q     <= '0;
         tmr           <= '0;
         idx           <= '0;
         am_max        <= '0;
         am_best       <= '0;
         am_tie        <= 1'b0;
         class_o       <= '0;
         class_count_o <= '0;
         tie_o         <= 1'b0;
         for (int i = 0; i < NUM_OUTPUTS; i++)
            cnt[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i)
                  pattern_q <= pattern_i;
            end
            S_CLEAR: begin
               tmr <= RUN_LOAD;
               idx <= '0;
               for (int i = 0; i < NUM_OUTPUTS; i++)
                  cnt[i] <= '0;
            end
            S_RUN: begin
               for (int i = 0; i < NUM_OUTPUTS; i++)
                  cnt[i] <= cnt_upd[i];
               tmr <= (tmr_zero || early_hit) ? DRAIN_LOAD : tmr - TMR_W'(1);
            end
            S_DRAIN: begin
               for (int i = 0; i < NUM_OUTPUTS; i++)
                  cnt[i] <= cnt_upd[i];
               if (!tmr_zero)
                  tmr <= tmr - TMR_W'(1);
            end
            S_ARGMAX: begin
               am_max  <= am_max_n;
               am_best <= am_best_n;
               am_tie  <= am_tie_n;
               idx     <= idx + IDX_W'(1);
               if (idx_last && !abort_i) begin
                  class_o       <= 4'(am_best_n);
                  class_count_o <= am_max_n;
                  tie_o         <= am_tie_n;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
